clock_time_setter: RTL and testbench

- Key-driven time-set controller for the digital clock.
- Consumes debounced key levels and the live BCD time from the counter.
- Lets the user edit hours/minutes/seconds, then drives a one-cycle load strobe with the new BCD time back into the counter.
- Provides a per-digit blink mask for the seven-segment scanner so the field being edited flashes.

---
 rtl/clock_time_setter_if.sv | 18 +
 rtl/clock_time_setter.sv | 144 ++++++++++++++
 tb/tb_clock_time_setter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_time_setter_if.sv
// Bundle between the time-set controller, the key debouncer, the time counter and the display scanner.
interface clock_time_setter_if;
   logic [7:0] key_in;
   logic [3:0] cur_h2, cur_h1, cur_m2, cur_m1, cur_s2, cur_s1;
   logic [3:0] set_h2, set_h1, set_m2, set_m1, set_s2, set_s1;
   logic       load;
   logic       set_mode;
   logic [5:0] blink_en;

   modport master (
      output key_in, cur_h2, cur_h1, cur_m2, cur_m1, cur_s2, cur_s1,
      input  set_h2, set_h1, set_m2, set_m1, set_s2, set_s1, load, set_mode, blink_en
   );
   modport slave (
      input  key_in, cur_h2, cur_h1, cur_m2, cur_m1, cur_s2, cur_s1,
      output set_h2, set_h1, set_m2, set_m1, set_s2, set_s1, load, set_mode, blink_en
   );
endinterface

// File: rtl/clock_time_setter.sv
// Key-driven hh:mm:ss editor: captures the live time, edits one BCD field at a time,
// strobes the result back into the counter, and blinks the field under edit.
module clock_time_setter #(
   parameter int BLINK_DIV     = 25_000_000,
   parameter int TIMEOUT_HALFS = 20
) (
   input  logic                 CLK_50M,
   input  logic                 RST,
   clock_time_setter_if.slave   bus
);
   localparam int CW = $clog2(BLINK_DIV);
   localparam int TW = $clog2(TIMEOUT_HALFS + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EDIT_H = 2'd1;
   localparam logic [1:0] S_EDIT_M = 2'd2;
   localparam logic [1:0] S_EDIT_S = 2'd3;

   logic [1:0]      r_state, w_next;
   logic [7:0]      r_key_prev, r_armed;
   logic [5:0][3:0] r_set;
   logic            r_load, r_set_mode, r_phase;
   logic [CW-1:0]   r_cnt;
   logic [TW-1:0]   r_tmo;

   logic [7:0]      w_press;
   logic            w_cancel, w_ok, w_mode, w_up, w_down;
   logic            w_editing, w_accept, w_timeout;
   logic [5:0][3:0] w_cur;
   logic [2:0]      w_lo_idx;
   logic [3:0]      w_hi, w_lo, w_mhi, w_mlo;
   logic [7:0]      w_new;
   logic [5:0]      w_mask;

   // A key that is down while reset is released stays disarmed until it is seen high.
   assign w_press   = r_key_prev & ~bus.key_in & r_armed;
   assign w_cancel  = w_press[4];
   assign w_ok      = w_press[3] & ~w_cancel;
   assign w_mode    = w_press[0] & ~w_press[4] & ~w_press[3];
   assign w_up      = w_press[1] & ~w_press[4] & ~w_press[3] & ~w_press[0];
   assign w_down    = w_press[2] & ~w_press[4] & ~w_press[3] & ~w_press[0] & ~w_press[1];
   assign w_editing = (r_state != S_IDLE);
   assign w_accept  = w_editing ? (|w_press[4:0]) : w_press[0];
   assign w_timeout = w_editing & ~w_accept & (r_cnt == CW'(BLINK_DIV - 1))
                    & (r_tmo == TW'(TIMEOUT_HALFS - 1));

   assign w_cur = {bus.cur_h2, bus.cur_h1, bus.cur_m2, bus.cur_m1, bus.cur_s2, bus.cur_s1};

   // Field digit pair: hours at [5:4], minutes at [3:2], seconds at [1:0].
   assign w_lo_idx = {2'd3 - r_state, 1'b0};
   assign w_hi     = r_set[w_lo_idx + 3'd1];
   assign w_lo     = r_set[w_lo_idx];
   assign w_mhi    = (r_state == S_EDIT_H) ? 4'd2 : 4'd5;
   assign w_mlo    = (r_state == S_EDIT_H) ? 4'd3 : 4'd9;

   function automatic logic bcd_bad(input logic [3:0] hi, lo, mhi, mlo);
      return (hi > 4'd9) || (lo > 4'd9) || (hi > mhi) || ((hi == mhi) && (lo > mlo));
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [3:0] hi, lo, mhi, mlo);
      if (bcd_bad(hi, lo, mhi, mlo) || ((hi == mhi) && (lo == mlo))) return 8'h00;
      if (lo == 4'd9) return {hi + 4'd1, 4'd0};
      return {hi, lo + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [3:0] hi, lo, mhi, mlo);
      if (bcd_bad(hi, lo, mhi, mlo)) return 8'h00;
      if ((hi == 4'd0) && (lo == 4'd0)) return {mhi, mlo};
      if (lo == 4'd0) return {hi - 4'd1, 4'd9};
      return {hi, lo - 4'd1};
   endfunction

   assign w_new = w_up ? bcd_inc(w_hi, w_lo, w_mhi, w_mlo) : bcd_dec(w_hi, w_lo, w_mhi, w_mlo);

   always_comb begin
      w_next = r_state;
      if (!w_editing) begin
         if (w_press[0]) w_next = S_EDIT_H;
      end else if (w_cancel || w_ok || w_timeout) begin
         w_next = S_IDLE;
      end else if (w_mode) begin
         w_next = (r_state == S_EDIT_S) ? S_EDIT_H : r_state + 2'd1;
      end
   end

   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_load     <= 1'b0;
         r_set_mode <= 1'b0;
         r_set      <= '0;
         r_key_prev <= 8'hFF;
         r_armed    <= bus.key_in;
         r_cnt      <= '0;
         r_phase    <= 1'b0;
         r_tmo      <= '0;
      end else begin
         r_key_prev <= bus.key_in;
         r_armed    <= r_armed | bus.key_in;
         r_state    <= w_next;
         r_set_mode <= (w_next != S_IDLE);
         r_load     <= w_editing & w_ok;
         if (!w_editing && w_press[0]) begin
            r_set <= w_cur;
         end else if (w_editing && (w_up || w_down)) begin
            r_set[w_lo_idx + 3'd1] <= w_new[7:4];
            r_set[w_lo_idx]        <= w_new[3:0];
         end
         if (!w_editing || w_accept || w_timeout) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_tmo   <= '0;
         end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
            r_tmo   <= r_tmo + TW'(1);
         end else begin
            r_cnt   <= r_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      w_mask = 6'b000000;
      if (r_phase) begin
         case (r_state)
            S_EDIT_H: w_mask = 6'b110000;
            S_EDIT_M: w_mask = 6'b001100;
            S_EDIT_S: w_mask = 6'b000011;
            default:  w_mask = 6'b000000;
         endcase
      end
   end

   assign bus.set_h2   = r_set[5];
   assign bus.set_h1   = r_set[4];
   assign bus.set_m2   = r_set[3];
   assign bus.set_m1   = r_set[2];
   assign bus.set_s2   = r_set[1];
   assign bus.set_s1   = r_set[0];
   assign bus.load     = r_load;
   assign bus.set_mode = r_set_mode;
   assign bus.blink_en = w_mask;
endmodule

// File: tb/tb_clock_time_setter.sv
// Directed plus random checks of the time-set controller against a field-arithmetic reference model.
module tb_clock_time_setter;
   localparam int BD = 4;
   localparam int TH = 3;

   logic        clk;
   logic        RST;
   logic [23:0] cur;
   int          n_assert, n_fail;

   clock_time_setter_if ifc ();

   clock_time_setter #(.BLINK_DIV(BD), .TIMEOUT_HALFS(TH)) dut (
      .CLK_50M (clk),
      .RST     (RST),
      .bus     (ifc)
   );

   assign ifc.cur_h2 = cur[23:20];
   assign ifc.cur_h1 = cur[19:16];
   assign ifc.cur_m2 = cur[15:12];
   assign ifc.cur_m1 = cur[11:8];
   assign ifc.cur_s2 = cur[7:4];
   assign ifc.cur_s1 = cur[3:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: state 0=idle 1=hours 2=minutes 3=seconds; m_t counts cycles since the last
   // accepted key, from which blink phase and timeout follow directly.
   int         m_state, m_t;
   int         ms [6];
   logic [7:0] m_prev, m_rel;
   logic       m_load;

   task automatic model(input logic [7:0] k, input logic r);
      logic [7:0] p;
      int hi, lo, mx, v;
      m_load = 1'b0;
      if (r) begin
         m_state = 0; m_t = 0; m_prev = 8'hFF; m_rel = k;
         for (int i = 0; i < 6; i++) ms[i] = 0;
         return;
      end
      p = m_prev & ~k & m_rel;
      m_rel = m_rel | k;
      m_prev = k;
      if (m_state == 0) begin
         if (p[0]) begin
            for (int i = 0; i < 6; i++) ms[i] = int'(cur[4*i +: 4]);
            m_state = 1; m_t = 0;
         end
      end else if (p[4:0] != 5'd0) begin
         m_t = 0;
         if (p[4]) m_state = 0;
         else if (p[3]) begin m_state = 0; m_load = 1'b1; end
         else if (p[0]) m_state = m_state % 3 + 1;
         else begin
            hi = 7 - 2 * m_state; lo = hi - 1;
            mx = (m_state == 1) ? 23 : 59;
            v  = (ms[hi] <= 9 && ms[lo] <= 9) ? ms[hi] * 10 + ms[lo] : -1;
            if (v < 0 || v > mx) v = 0;
            else if (p[1]) v = (v + 1) % (mx + 1);
            else v = (v + mx) % (mx + 1);
            ms[hi] = v / 10; ms[lo] = v % 10;
         end
      end else begin
         m_t++;
         if (m_t == BD * TH) begin m_state = 0; m_t = 0; end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] dut_set();
      return {ifc.set_h2, ifc.set_h1, ifc.set_m2, ifc.set_m1, ifc.set_s2, ifc.set_s1};
   endfunction

   task automatic check_model();
      logic [23:0] e;
      logic [5:0]  b;
      for (int i = 0; i < 6; i++) e[4*i +: 4] = ms[i][3:0];
      b = 6'd0;
      if (m_state != 0 && ((m_t / BD) % 2) == 1) b = 6'b000011 << (2 * (3 - m_state));
      chk("set", 32'(dut_set()), 32'(e));
      chk("load", 32'(ifc.load), 32'(m_load));
      chk("set_mode", 32'(ifc.set_mode), 32'(m_state != 0));
      chk("blink_en", 32'(ifc.blink_en), 32'(b));
   endtask

   task automatic step(input logic [7:0] k, input logic r);
      ifc.key_in = k;
      RST = r;
      @(posedge clk);
      model(k, r);
      #1;
      check_model();
   endtask

   task automatic press(input logic [7:0] keys);
      step(~keys, 1'b0);
      step(8'hFF, 1'b0);
   endtask

   task automatic enter(input logic [23:0] c);
      press(8'h10);
      cur = c;
      press(8'h01);
   endtask

   initial begin
      logic [7:0] k;
      int hold;
      n_assert = 0; n_fail = 0;
      cur = 24'h000000; ifc.key_in = 8'hFF; RST = 1'b1;
      #1;
      step(8'hFF, 1'b1);
      step(8'hFF, 1'b1);
      chk("rst_set", 32'(dut_set()), 32'h0);
      chk("rst_mode", 32'(ifc.set_mode), 32'h0);
      chk("rst_blink", 32'(ifc.blink_en), 32'h0);

      // Capture and blink cadence
      cur = 24'h123456;
      press(8'h01);
      chk("capture", 32'(dut_set()), 32'h123456);
      chk("capture_mode", 32'(ifc.set_mode), 32'h1);
      for (int i = 0; i < 3; i++) step(8'hFF, 1'b0);
      chk("blink_on", 32'(ifc.blink_en), 32'h30);
      for (int i = 0; i < 4; i++) step(8'hFF, 1'b0);
      chk("blink_off", 32'(ifc.blink_en), 32'h00);

      // Hour wrap and carry
      enter(24'h233456);
      press(8'h02); chk("h23_up", 32'(dut_set()), 32'h003456);
      press(8'h04); chk("h00_dn", 32'(dut_set()), 32'h233456);
      enter(24'h093456);
      press(8'h02); chk("h09_up", 32'(dut_set()), 32'h103456);
      enter(24'h193456);
      press(8'h02); chk("h19_up", 32'(dut_set()), 32'h203456);

      // Seconds wrap then commit
      enter(24'h123459);
      press(8'h01); press(8'h01);
      press(8'h02); chk("s59_up", 32'(dut_set()), 32'h123400);
      step(~8'h08, 1'b0);
      chk("ok_load", 32'(ifc.load), 32'h1);
      chk("ok_mode", 32'(ifc.set_mode), 32'h0);
      chk("ok_blink", 32'(ifc.blink_en), 32'h0);
      step(8'hFF, 1'b0);
      chk("ok_load_drop", 32'(ifc.load), 32'h0);
      chk("ok_hold", 32'(dut_set()), 32'h123400);

      // Cancel, and cancel beating OK
      enter(24'h120000);
      press(8'h01); press(8'h10);
      chk("cancel_set", 32'(dut_set()), 32'h120000);
      chk("cancel_mode", 32'(ifc.set_mode), 32'h0);
      enter(24'h120000);
      step(~8'h18, 1'b0);
      chk("okcan_load", 32'(ifc.load), 32'h0);
      chk("okcan_mode", 32'(ifc.set_mode), 32'h0);
      step(8'hFF, 1'b0);

      // Held key gives one increment (edit then times out while holding)
      enter(24'h123456);
      for (int i = 0; i < 100; i++) step(~8'h02, 1'b0);
      step(8'hFF, 1'b0);
      chk("hold_up", 32'(dut_set()), 32'h133456);

      // Timeout after TH*BD idle cycles
      enter(24'h123456);
      for (int i = 0; i < 10; i++) step(8'hFF, 1'b0);
      chk("tmo_before", 32'(ifc.set_mode), 32'h1);
      step(8'hFF, 1'b0);
      chk("tmo_after", 32'(ifc.set_mode), 32'h0);
      chk("tmo_load", 32'(ifc.load), 32'h0);

      // Reset mid-edit
      enter(24'h123456);
      press(8'h01); press(8'h01);
      step(8'hFF, 1'b1);
      chk("rst_edit_set", 32'(dut_set()), 32'h0);
      chk("rst_edit_mode", 32'(ifc.set_mode), 32'h0);

      // Non-BCD capture cleared on edit
      enter(24'h1F3456);
      press(8'h02); chk("bad_up", 32'(dut_set()), 32'h003456);

      // Key held through reset
      step(~8'h01, 1'b1);
      step(~8'h01, 1'b1);
      for (int i = 0; i < 3; i++) step(~8'h01, 1'b0);
      chk("held_rst", 32'(ifc.set_mode), 32'h0);
      step(8'hFF, 1'b0);
      press(8'h01);
      chk("held_rearm", 32'(ifc.set_mode), 32'h1);

      // Random key traffic
      k = 8'hFF; hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            hold = int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 0) k = 8'hFF;
            else begin
               k = 8'hFF & ~(8'h01 << $urandom_range(0, 4));
               if ($urandom_range(0, 4) == 0) k = k & ~(8'h01 << $urandom_range(0, 4));
            end
            k[7:5] = 3'($urandom_range(0, 7));
         end
         hold--;
         if ($urandom_range(0, 40) == 0) cur = 24'($urandom);
         step(k, ($urandom_range(0, 200) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
